seg_display_ctrl: RTL and testbench



---
 rtl/seg_display_ctrl.sv | 145 ++++++++++++++
 tb/tb_seg_display_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/seg_display_ctrl.sv
// Memory-mapped 4-digit seven-segment display peripheral on the MEM-stage bus.
// Holds a 16-bit hex value and scans its digits onto active-low leds/an pins.
module seg_display_ctrl #(
    parameter logic [31:0] BASE_ADDR = 32'h4000_0010,
    parameter int unsigned SCAN_DIV  = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] Address,
    input  logic [31:0] Write_data,
    output logic [31:0] Read_data,
    output logic [6:0]  leds,
    output logic [3:0]  an
);

    localparam logic [31:0] CTRL_ADDR = BASE_ADDR + 32'd4;
    localparam logic [19:0] CNT_MAX   = 20'(SCAN_DIV - 1);

    logic [15:0] data_q, data_d;
    logic [1:0]  ctrl_q, ctrl_d;
    logic [19:0] cnt_q, cnt_d;
    logic [1:0]  idx_q, idx_d;
    logic [3:0]  an_q, an_d;
    logic [6:0]  leds_q, leds_d;

    logic        hit_data;
    logic        hit_ctrl;
    logic [3:0]  nibble;
    logic        upper_zero;
    logic        blank;

    function automatic logic [6:0] seg(input logic [3:0] v);
        logic [6:0] s;
        unique case (v)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            4'hF: s = 7'b0001110;
        endcase
        return s;
    endfunction

    assign hit_data = (Address == BASE_ADDR);
    assign hit_ctrl = (Address == CTRL_ADDR);

    always_comb begin
        data_d = data_q;
        ctrl_d = ctrl_q;
        if (MemWrite && hit_data) begin
            data_d = Write_data[15:0];
        end
        if (MemWrite && hit_ctrl) begin
            ctrl_d = Write_data[1:0];
        end
    end

    // Scan timing is independent of EN so re-enabling lands mid-rotation.
    always_comb begin
        cnt_d = cnt_q + 20'd1;
        idx_d = idx_q;
        if (cnt_q == CNT_MAX) begin
            cnt_d = 20'd0;
            idx_d = idx_q + 2'd1;
        end
    end

    always_comb begin
        nibble     = data_q[3:0];
        upper_zero = 1'b0;
        unique case (idx_q)
            2'd0: begin
                nibble     = data_q[3:0];
                upper_zero = 1'b0;
            end
            2'd1: begin
                nibble     = data_q[7:4];
                upper_zero = (data_q[15:4] == 12'd0);
            end
            2'd2: begin
                nibble     = data_q[11:8];
                upper_zero = (data_q[15:8] == 8'd0);
            end
            2'd3: begin
                nibble     = data_q[15:12];
                upper_zero = (data_q[15:12] == 4'd0);
            end
        endcase
    end

    assign blank = ctrl_q[1] & upper_zero;

    always_comb begin
        an_d   = 4'b1111;
        leds_d = 7'b1111111;
        if (ctrl_q[0] && !blank) begin
            an_d   = ~(4'b0001 << idx_q);
            leds_d = seg(nibble);
        end
    end

    always_comb begin
        Read_data = 32'h0;
        if (MemRead && hit_data) begin
            Read_data = {16'h0, data_q};
        end else if (MemRead && hit_ctrl) begin
            Read_data = {30'h0, ctrl_q};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= 16'h0;
            ctrl_q <= 2'b01;
            cnt_q  <= 20'd0;
            idx_q  <= 2'd0;
            an_q   <= 4'b1111;
            leds_q <= 7'b1111111;
        end else begin
            data_q <= data_d;
            ctrl_q <= ctrl_d;
            cnt_q  <= cnt_d;
            idx_q  <= idx_d;
            an_q   <= an_d;
            leds_q <= leds_d;
        end
    end

    assign an   = an_q;
    assign leds = leds_q;

endmodule

// File: tb/tb_seg_display_ctrl.sv
// Bench for seg_display_ctrl: cycle-level model comparison plus
// hand-computed spot checks of scan timing, blanking and bus access.
module tb_seg_display_ctrl;

    localparam logic [31:0] BASE = 32'h4000_0010;
    localparam int          DIV  = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        MemRead = 1'b0;
    logic        MemWrite = 1'b0;
    logic [31:0] Address = 32'h0;
    logic [31:0] Write_data = 32'h0;
    logic [31:0] Read_data;
    logic [6:0]  leds;
    logic [3:0]  an;

    int checks = 0;
    int errors = 0;

    seg_display_ctrl #(.BASE_ADDR(BASE), .SCAN_DIV(DIV)) dut (
        .clk(clk), .rst(rst), .MemRead(MemRead), .MemWrite(MemWrite),
        .Address(Address), .Write_data(Write_data), .Read_data(Read_data),
        .leds(leds), .an(an)
    );

    always #5 clk = ~clk;

    logic [6:0] seg_tab [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: n counts clock edges since reset release; digit = (n/DIV)%4.
    int          n = 0;
    logic [15:0] m_data = 16'h0;
    logic [1:0]  m_ctrl = 2'b01;
    logic [3:0]  exp_an = 4'hF;
    logic [6:0]  exp_leds = 7'h7F;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            n        <= 0;
            m_data   <= 16'h0;
            m_ctrl   <= 2'b01;
            exp_an   <= 4'hF;
            exp_leds <= 7'h7F;
        end else begin
            int  i;
            logic blk;
            i   = (n / DIV) % 4;
            blk = m_ctrl[1] && (i > 0) && ((m_data >> (4 * i)) == 16'h0);
            if (m_ctrl[0] && !blk) begin
                exp_an   <= 4'hF & ~(4'(1 << i));
                exp_leds <= seg_tab[(m_data >> (4 * i)) & 16'hF];
            end else begin
                exp_an   <= 4'hF;
                exp_leds <= 7'h7F;
            end
            if (MemWrite && Address == BASE) m_data <= Write_data[15:0];
            if (MemWrite && Address == BASE + 32'd4) m_ctrl <= Write_data[1:0];
            n <= n + 1;
        end
    end

    function automatic logic [31:0] model_read();
        if (MemRead && Address == BASE) return {16'h0, m_data};
        if (MemRead && Address == BASE + 32'd4) return {30'h0, m_ctrl};
        return 32'h0;
    endfunction

    always @(negedge clk) begin
        check("model_an", {28'h0, an}, {28'h0, exp_an});
        check("model_leds", {25'h0, leds}, {25'h0, exp_leds});
        check("model_read", Read_data, model_read());
    end

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        MemWrite = 1'b1; Address = a; Write_data = d;
        @(posedge clk); #1;
        MemWrite = 1'b0; Address = 32'h0;
        @(posedge clk); #1;
    endtask

    task automatic rd(input string name, input logic [31:0] a,
                      input logic [31:0] exp);
        @(posedge clk); #1;
        MemRead = 1'b1; Address = a;
        @(negedge clk);
        check(name, Read_data, exp);
        @(posedge clk); #1;
        MemRead = 1'b0; Address = 32'h0;
    endtask

    task automatic wait_an(input string name, input logic [3:0] target,
                           input logic [6:0] exp_seg);
        bit found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (an == target) found = 1'b1;
        end
        check({name, "_found"}, {31'h0, found}, 32'h1);
        check({name, "_leds"}, {25'h0, leds}, {25'h0, exp_seg});
    endtask

    initial begin
        int bad;
        rst = 1'b1;
        #1;
        check("rst_an", {28'h0, an}, 32'hF);
        check("rst_leds", {25'h0, leds}, 32'h7F);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        @(posedge clk); @(negedge clk);
        check("c1_an", {28'h0, an}, 32'hE);
        check("c1_leds", {25'h0, leds}, {25'h0, 7'b1000000});
        repeat (4) @(posedge clk); @(negedge clk);
        check("c5_an", {28'h0, an}, 32'hD);
        repeat (4) @(posedge clk); @(negedge clk);
        check("c9_an", {28'h0, an}, 32'hB);
        repeat (4) @(posedge clk); @(negedge clk);
        check("c13_an", {28'h0, an}, 32'h7);
        repeat (4) @(posedge clk); @(negedge clk);
        check("c17_an", {28'h0, an}, 32'hE);

        wr(BASE, 32'hABCD_1F80);
        rd("rd_1f80", BASE, 32'h0000_1F80);
        wait_an("d0_1f80", 4'b1110, 7'b1000000);
        wait_an("d1_1f80", 4'b1101, 7'b0000000);
        wait_an("d2_1f80", 4'b1011, 7'b0001110);
        wait_an("d3_1f80", 4'b0111, 7'b1111001);

        wr(BASE + 32'd4, 32'h3);
        wr(BASE, 32'h0000_0005);
        rd("rd_ctrl3", BASE + 32'd4, 32'h3);
        wait_an("lzb_d0", 4'b1110, 7'b0010010);
        wr(BASE, 32'h0000_0400);
        wait_an("lzb_d2", 4'b1011, 7'b0011001);
        wait_an("lzb_d1", 4'b1101, 7'b1000000);

        wr(BASE + 32'd4, 32'h0);
        bad = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (an != 4'hF || leds != 7'h7F) bad++;
        end
        check("dis_dark", bad, 0);
        wr(BASE + 32'd4, 32'h1);

        wr(BASE + 32'd8, 32'hFFFF_FFFF);
        wr(32'h0000_0010, 32'hFFFF_FFFF);
        rd("rd_data_kept", BASE, 32'h0400);
        rd("rd_ctrl_kept", BASE + 32'd4, 32'h1);
        rd("rd_off8", BASE + 32'd8, 32'h0);
        rd("rd_low", 32'h0000_0010, 32'h0);
        @(posedge clk); #1;
        Address = BASE;
        @(negedge clk);
        check("rd_noread", Read_data, 32'h0);

        @(posedge clk); #1;
        MemRead = 1'b1; MemWrite = 1'b1; Address = BASE;
        Write_data = 32'h0000_1234;
        @(negedge clk);
        check("rw_old", Read_data, 32'h0400);
        @(posedge clk); #1;
        MemWrite = 1'b0;
        @(negedge clk);
        check("rw_new", Read_data, 32'h1234);
        @(posedge clk); #1;
        MemRead = 1'b0; Address = 32'h0;

        wait_an("pre_rst_d2", 4'b1011, 7'b0100100);
        #2 rst = 1'b1;
        #1;
        check("arst_an", {28'h0, an}, 32'hF);
        check("arst_leds", {25'h0, leds}, 32'h7F);
        MemRead = 1'b1; Address = BASE;
        #1;
        check("arst_data", Read_data, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0; MemRead = 1'b0; Address = 32'h0;
        @(posedge clk); @(negedge clk);
        check("post_rst_an", {28'h0, an}, 32'hE);
        check("post_rst_leds", {25'h0, leds}, {25'h0, 7'b1000000});

        repeat (4) @(posedge clk);
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
